// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu with
// a busy countdown, the HI/LO registers, and the mfhi/mflo/mthi/mtlo accesses.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Ctr,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDU_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic [31:0] abs_a, abs_b, div_a, div_b_raw, div_b, quo, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_wr, is_arith, is_mult;

  assign E_Busy = (cnt != '0);

  // Signed divide runs on magnitudes through the shared unsigned divider; this
  // also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign abs_a     = E_A[31] ? -E_A : E_A;
  assign abs_b     = E_B[31] ? -E_B : E_B;
  assign div_a     = (E_MDU_Ctr == OP_DIV) ? abs_a : E_A;
  assign div_b_raw = (E_MDU_Ctr == OP_DIV) ? abs_b : E_B;
  assign div_b     = (div_b_raw == '0) ? 32'd1 : div_b_raw;
  assign quo       = div_a / div_b;
  assign rem       = div_a % div_b;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    res_wr   = 1'b0;
    is_arith = 1'b0;
    is_mult  = 1'b0;
    case (E_MDU_Ctr)
      OP_MULT: begin
        {res_hi, res_lo} = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        res_wr   = 1'b1;
        is_arith = 1'b1;
        is_mult  = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = {32'd0, E_A} * {32'd0, E_B};
        res_wr   = 1'b1;
        is_arith = 1'b1;
        is_mult  = 1'b1;
      end
      OP_DIV: begin
        res_lo   = (E_A[31] ^ E_B[31]) ? -quo : quo;
        res_hi   = E_A[31] ? -rem : rem;
        res_wr   = (E_B != '0);
        is_arith = 1'b1;
      end
      OP_DIVU: begin
        res_lo   = quo;
        res_hi   = rem;
        res_wr   = (E_B != '0);
        is_arith = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (E_MDU_Ctr)
      OP_MFHI: E_MDU_out = HI;
      OP_MFLO: E_MDU_out = LO;
      default: E_MDU_out = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (E_Busy) begin
      // While busy, starts and mthi/mtlo are ignored; a divide by zero commits nothing.
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (E_start && is_arith) begin
      cnt     <= is_mult ? MULT_LOAD : DIV_LOAD;
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end else if (E_MDU_Ctr == OP_MTHI) begin
      HI <= E_A;
    end else if (E_MDU_Ctr == OP_MTLO) begin
      LO <= E_A;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected commits, a negedge
// monitor pops one whenever E_Busy falls and checks busy length and HI/LO.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDU_Ctr;
  logic        E_start;
  logic [31:0] E_A, E_B;
  logic        E_Busy;
  logic [31:0] HI, LO, E_MDU_out;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDU_Ctr (E_MDU_Ctr),
    .E_start   (E_start),
    .E_A       (E_A),
    .E_B       (E_B),
    .E_Busy    (E_Busy),
    .HI        (HI),
    .LO        (LO),
    .E_MDU_out (E_MDU_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each falling edge of busy, compare against the oldest expectation.
  int   run = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      run       = 0;
      prev_busy = 1'b0;
    end else begin
      if (E_Busy) begin
        run++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("busy_len", 32'(run), 32'(e.len));
          check("commit_hi", HI, e.hi);
          check("commit_lo", LO, e.lo);
        end
        run = 0;
      end
      prev_busy = E_Busy;
    end
  end

  task automatic expect_commit(input int len, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.len = len;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    E_MDU_Ctr = op;
    E_A       = a;
    E_B       = b;
    E_start   = st;
    @(posedge clk);
    #1;
    E_MDU_Ctr = 4'd0;
    E_start   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!E_Busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    E_MDU_Ctr = 4'd0;
    E_start   = 1'b0;
    E_A       = '0;
    E_B       = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(E_Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_out_none", E_MDU_out, 32'd0);
    @(posedge clk);
    #1;

    // mult -3 * 5
    expect_commit(5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    check("mult_busy_rise", 32'(E_Busy), 32'd1);
    wait_idle(20);

    // multu same operands
    expect_commit(5, 32'h0000_0004, 32'hFFFF_FFF1);
    issue(4'd2, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_idle(20);

    // div -7 / 2, divu 7 / 2
    expect_commit(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle(30);
    expect_commit(10, 32'd1, 32'd3);
    issue(4'd4, 32'd7, 32'd2, 1'b1);
    wait_idle(30);

    // mthi/mtlo single-cycle writes, then div by zero leaves them intact
    issue(4'd7, 32'h11, 32'd0, 1'b0);
    check("mthi_hi", HI, 32'h11);
    check("mthi_busy", 32'(E_Busy), 32'd0);
    issue(4'd8, 32'h22, 32'd0, 1'b0);
    check("mtlo_lo", LO, 32'h22);
    E_MDU_Ctr = 4'd5;
    #1 check("mfhi_out", E_MDU_out, 32'h11);
    E_MDU_Ctr = 4'd0;
    expect_commit(10, 32'h11, 32'h22);
    issue(4'd3, 32'd5, 32'd0, 1'b1);
    wait_idle(30);

    // signed overflow
    expect_commit(10, 32'd0, 32'h8000_0000);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(30);

    // start with opcode 5 must not raise busy
    issue(4'd5, 32'd1, 32'd1, 1'b1);
    check("bad_start_busy", 32'(E_Busy), 32'd0);

    // mult 0x10000 * 0x10000 with an ignored div start and mtlo mid-flight
    expect_commit(5, 32'd1, 32'd0);
    issue(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    issue(4'd8, 32'h55, 32'd0, 1'b0);
    E_MDU_Ctr = 4'd6;
    #1 check("mflo_during_busy", E_MDU_out, 32'h8000_0000);
    E_MDU_Ctr = 4'd0;
    wait_idle(20);

    // back-to-back: second mult issued in the first idle cycle
    expect_commit(5, 32'd0, 32'd12);
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    wait_idle(20);
    expect_commit(5, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    issue(4'd1, 32'd7, 32'hFFFF_FFFF, 1'b1);
    check("b2b_busy", 32'(E_Busy), 32'd1);
    wait_idle(20);

    // asynchronous reset during the third busy cycle of a div
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(E_Busy), 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(E_Busy), 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Executes mult/multu/div/divu as multi-cycle operations and holds the HI/LO architectural registers.
- Services mfhi/mflo/mthi/mtlo.
- Drives the `start`/`busy` handshake that the D-stage hazard unit consumes. The hazard unit stalls D when (start|busy) and the D-stage MDU opcode is non-zero.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (must be ≥1)
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- E_MDU_Ctr  input  4  opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none
- E_start  input  1  one-cycle pulse, accompanies opcodes 1-4 in the issuing cycle
- E_A  input  32  rs operand
- E_B  input  32  rt operand
- E_Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- E_MDU_out  output  32  HI if opcode 5, LO if opcode 6, else 0 (combinational)

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, E_Busy=0, internal counter=0, pending result registers=0. Any in-flight operation is discarded.
- Accepted start:
  - Condition: E_start=1, E_MDU_Ctr in 1..4, E_Busy=0 at edge T.
  - Result computed from E_A/E_B sampled at T and held in pending registers.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES.
- E_Busy = (counter != 0). It is high for exactly N cycles, starting the cycle after T.
- Counter decrements by 1 each edge while non-zero.
- Commit: on the edge where the counter goes 1→0, HI/LO take the pending values and E_Busy falls. The new HI/LO are visible in the first non-busy cycle.
- Arithmetic:
  - mult: signed 32x32 → 64; HI = [63:32], LO = [31:0].
  - multu: same with unsigned operands.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (E_A).
  - divu: unsigned quotient and remainder.
- Divide by zero (E_B=0, div/divu): full busy period still runs; HI/LO unchanged at commit.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- E_start while E_Busy=1: ignored, no restart, no change to the pending result. The hazard unit prevents this case, but it is defined anyway.
- E_start=1 with opcode not in 1..4: ignored.
- mthi / mtlo:
  - With E_Busy=0: HI (resp. LO) ← E_A at the edge. Takes effect in a single cycle and never raises busy.
  - With E_Busy=1: ignored.
- mfhi / mflo: combinational read of the current HI/LO. During busy they return the pre-operation values.
- Opcode 0 or 9-15: E_MDU_out=0; no state change.
- Cycle where a commit and a new start coincide: the commit happens first; the new start is not accepted, because E_Busy is still 1 at that edge.

Test Plan:
- mult E_A=0xFFFFFFFD (-3), E_B=5, start at T → E_Busy high T+1..T+5; after commit HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu on the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- div E_A=-7, E_B=2 → E_Busy high for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 → LO=3, HI=1.
- div by zero with HI=0x11, LO=0x22 preset via mthi/mtlo → after 10 busy cycles HI=0x11, LO=0x22; mthi writes are observed in one cycle with E_Busy staying 0.
- Mid-mult: E_start pulse with div (E_A=100, E_B=7), plus mtlo E_A=0x55 → both ignored; final HI/LO reflect the original mult only. mflo during busy returns the old LO.
- reset driven low asynchronously (mid-clock) on cycle 3 of a div → E_Busy, HI, LO become 0 immediately; no later commit occurs after reset is released.
- Back-to-back: mult issued on the first cycle after E_Busy falls → accepted; E_Busy high for 5 more cycles; a second result overwrites the first.
